// File: rtl/window_pkg.sv
// ============================================================================
// window_pkg : shared sizing constants and slice helpers for the window path
// Revision   : 1.0
// ============================================================================
`default_nettype none

package window_pkg;

  localparam int DEF_DW  = 8;
  localparam int DEF_N   = 4;
  localparam int DEF_LAT = 4;

  localparam int WIN   = 2**DEF_N;
  localparam int CNT_W = DEF_N + 1;

  function automatic int win_depth(input int n);
    return 1 << n;
  endfunction

  // Lowest bit of slice k in a flat bus of dw-bit slices: [k*dw +: dw]
  function automatic int slice_lo(input int k, input int dw);
    return k * dw;
  endfunction

endpackage

`default_nettype wire

// File: rtl/valid_delay_line.sv
// ============================================================================
// valid_delay_line : LAT-stage shift register for a single valid strobe,
//                    with synchronous flush of all in-flight strobes.
// Revision         : 1.0
// ============================================================================
`default_nettype none

module valid_delay_line #(
  parameter int LAT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic flush,
  input  logic d,
  output logic q
);

  logic [LAT-1:0] stage_q;
  logic [LAT-1:0] stage_d;

  always_comb begin
    stage_d    = stage_q;
    stage_d[0] = d;
    for (int i = 1; i < LAT; i++) begin
      stage_d[i] = stage_q[i-1];
    end
    if (flush) begin
      stage_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stage_q <= '0;
    end else begin
      stage_q <= stage_d;
    end
  end

  assign q = stage_q[LAT-1];

endmodule

`default_nettype wire

// File: rtl/sample_window_buffer.sv
// ============================================================================
// sample_window_buffer : 2^N-deep sliding sample window feeding a tree adder,
//                        with a full-window strobe and its LAT-delayed twin.
// Revision             : 1.0
// ============================================================================
`default_nettype none

module sample_window_buffer
  import window_pkg::*;
#(
  parameter int DW  = DEF_DW,
  parameter int N   = DEF_N,
  parameter int LAT = DEF_LAT
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      clear,
  input  logic                      in_valid,
  input  logic [DW-1:0]             in_data,
  output logic [(2**N)*DW-1:0]      win_data,
  output logic                      win_valid,
  output logic [N:0]                fill_count,
  output logic                      sum_valid
);

  localparam int               WIN_DEPTH = win_depth(N);
  localparam int               CNT_WIDTH = N + 1;
  localparam logic [CNT_WIDTH-1:0] FULL_CNT = CNT_WIDTH'(WIN_DEPTH);

  logic [WIN_DEPTH*DW-1:0] win_q;
  logic [WIN_DEPTH*DW-1:0] win_d;
  logic [CNT_WIDTH-1:0]    cnt_q;
  logic [CNT_WIDTH-1:0]    cnt_d;
  logic                    win_valid_q;
  logic                    win_valid_d;

  always_comb begin
    win_d       = win_q;
    cnt_d       = cnt_q;
    win_valid_d = 1'b0;
    if (clear) begin
      win_d = '0;
      cnt_d = '0;
    end else if (in_valid) begin
      // Slice 0 is newest; the oldest slice falls off the top
      for (int k = WIN_DEPTH - 1; k > 0; k--) begin
        win_d[slice_lo(k, DW) +: DW] = win_q[slice_lo(k - 1, DW) +: DW];
      end
      win_d[slice_lo(0, DW) +: DW] = in_data;
      cnt_d       = (cnt_q == FULL_CNT) ? cnt_q : cnt_q + 1'b1;
      win_valid_d = (cnt_d == FULL_CNT);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      win_q       <= '0;
      cnt_q       <= '0;
      win_valid_q <= 1'b0;
    end else begin
      win_q       <= win_d;
      cnt_q       <= cnt_d;
      win_valid_q <= win_valid_d;
    end
  end

  valid_delay_line #(
    .LAT (LAT)
  ) u_sum_valid_dly (
    .clk   (clk),
    .rst   (rst),
    .flush (clear),
    .d     (win_valid_q),
    .q     (sum_valid)
  );

  assign win_data   = win_q;
  assign win_valid  = win_valid_q;
  assign fill_count = cnt_q;

endmodule

`default_nettype wire
